pipe_scroller: RTL

Generates and scrolls the three pipe obstacles that feed collision_detector. It emits pipe_x1..3 and pipe_y1..3 in the same widths and coordinate convention the detector consumes: a gap spans pipe_y..pipe_y+30, and the box sits fixed at x=4. A frame-rate divider steps all pipes one pixel left per frame. Pipes leaving the left edge respawn on the right with an LFSR-chosen gap height. The block also counts pipes passed for the score display.

---
 rtl/pipe_scroller.sv | 83 ++++++++
 1 files changed

// File: rtl/pipe_scroller.sv
// pipe_scroller: frame-rate pipe generator/scroller with LFSR gap heights and pass scoring
module pipe_scroller #(
  parameter int TICK_DIV     = 833333,
  parameter int SCREEN_W     = 160,
  parameter int PIPE_SPACING = 54,
  parameter int GAP_H        = 30,
  parameter int Y_MIN        = 5,
  parameter int Y_MAX        = 85,
  parameter int BOX_X        = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  output logic [8:0] pipe_x1,
  output logic [6:0] pipe_y1,
  output logic [8:0] pipe_x2,
  output logic [6:0] pipe_y2,
  output logic [8:0] pipe_x3,
  output logic [6:0] pipe_y3,
  output logic       frame_tick,
  output logic       pass_pulse,
  output logic [7:0] score
);
  localparam int DW      = $clog2(TICK_DIV);
  localparam int Y_RANGE = Y_MAX - Y_MIN + 1;
  localparam int RESPAWN = 3 * PIPE_SPACING - 1;
  logic [DW-1:0] div_q, div_d;
  logic [7:0] lfsr_q, lfsr_d, score_q, score_d;
  logic [8:0] x_q [3];
  logic [8:0] x_d [3];
  logic [6:0] y_q [3];
  logic [6:0] y_d [3];
  logic       ft_q, ft_d, pp_q, pp_d, tick, hit;
  logic [6:0] r;
  always_comb begin
    tick    = enable && div_q == DW'(TICK_DIV - 1);
    div_d   = !enable ? div_q : tick ? '0 : div_q + DW'(1);
    lfsr_d  = lfsr_q == 8'h00 ? 8'h01 : {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    r       = lfsr_q[6:0] < 7'(Y_RANGE) ? lfsr_q[6:0] : lfsr_q[6:0] - 7'(Y_RANGE);
    hit     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hit    = hit | (x_q[k] == 9'(BOX_X));
      x_d[k] = !tick ? x_q[k] : x_q[k] == 9'd0 ? 9'(RESPAWN) : x_q[k] - 9'd1;
      y_d[k] = (tick && x_q[k] == 9'd0) ? 7'(Y_MIN) + r : y_q[k];
    end
    ft_d    = tick;
    pp_d    = tick && hit;
    score_d = (pp_d && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      x_q[0]  <= 9'(SCREEN_W);
      x_q[1]  <= 9'(SCREEN_W + PIPE_SPACING);
      x_q[2]  <= 9'(SCREEN_W + 2 * PIPE_SPACING);
      y_q[0]  <= 7'd25;
      y_q[1]  <= 7'd45;
      y_q[2]  <= 7'd65;
      ft_q    <= 1'b0;
      pp_q    <= 1'b0;
      score_q <= 8'd0;
    end else begin
      div_q   <= div_d;
      lfsr_q  <= lfsr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ft_q    <= ft_d;
      pp_q    <= pp_d;
      score_q <= score_d;
    end
  end
  assign pipe_x1    = x_q[0];
  assign pipe_x2    = x_q[1];
  assign pipe_x3    = x_q[2];
  assign pipe_y1    = y_q[0];
  assign pipe_y2    = y_q[1];
  assign pipe_y3    = y_q[2];
  assign frame_tick = ft_q;
  assign pass_pulse = pp_q;
  assign score      = score_q;
endmodule
